psum_acc: RTL
=============

PSUM_ACC -- requirements
Module: psum_acc

Interface
REQ-001 SHALL have parameter col, default 8: number of psum lanes, matching the upstream output FIFO.
REQ-002 SHALL have parameter psum_bw, default 16: signed two's-complement width of each lane.
REQ-003 SHALL have parameter len, default 16: number of output positions (vectors) per tile.
REQ-004 SHALL have parameter rd_lat, default 2: cycles from an o_rd pulse until i_data holds the popped vector.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port i_valid, input, 1: upstream FIFO has a full vector available in all lanes.
REQ-008 SHALL have port i_data, input, psum_bw*col: upstream psum vector; lane k is bits [psum_bw*(k+1)-1 : psum_bw*k].
REQ-009 SHALL have port o_rd, output, 1: pop request to the upstream FIFO.
REQ-010 SHALL have port start, input, 1: begin a tile.
REQ-011 SHALL have port npass, input, 4: passes to accumulate per position, sampled on an accepted start.
REQ-012 SHALL have port o_data, output, psum_bw*col: result vector, same lane packing as i_data.
REQ-013 SHALL have port o_valid, output, 1: o_data valid.
REQ-014 SHALL have port o_ready, input, 1: downstream accepts o_data.
REQ-015 SHALL have port busy, output, 1: state is not IDLE.
REQ-016 SHALL have port done, output, 1: one-cycle pulse at tile end.

Function
REQ-017 SHALL implement FSM states IDLE, ACC, OUT; reset state IDLE.
REQ-018 SHALL, in IDLE with start=1, latch npass and go to ACC with pos=0, pass=0.
- npass=0 is treated as 1.
REQ-019 SHALL ignore start outside IDLE.
REQ-020 SHALL, in ACC, assert o_rd for exactly one cycle when i_valid=1, no read is in flight, and fewer than len*npass reads have been issued.
REQ-021 SHALL capture i_data exactly rd_lat cycles after each o_rd pulse.
REQ-022 SHALL clear the in-flight condition on that capture; at most one read is in flight.
REQ-023 SHALL process each captured vector lane-wise:
- pass=0: acc[pos] = i_data.
- otherwise: acc[pos] = sat(acc[pos] + i_data).
REQ-024 SHALL, for sat, clamp the psum_bw+1-bit signed sum to [-2^(psum_bw-1), 2^(psum_bw-1)-1], independently per lane.
REQ-025 SHALL update counters after each capture:
- pos increments.
- pos=len-1 wraps pos to 0 and increments pass.
- Capture at pos=len-1, pass=npass-1 moves the FSM to OUT with pos=0.
REQ-026 SHALL, in OUT, drive o_valid=1 and o_data=f(acc[pos]); o_rd=0.
REQ-027 SHALL hold o_data stable while o_valid=1 and o_ready=0.
REQ-028 SHALL advance pos on o_valid&&o_ready; the handshake at pos=len-1 returns the FSM to IDLE and pulses done for one cycle.
REQ-029 SHALL drive o_valid=0 outside OUT.
REQ-030 SHALL NOT pop the upstream FIFO outside ACC, even when i_valid=1.

Reset
REQ-031 SHALL, on reset=0, asynchronously set the state to IDLE.
REQ-032 SHALL, on reset=0, clear pos, pass, the read counter, the in-flight flag, the rd_lat delay line and all acc entries to 0.
REQ-033 SHALL hold o_rd=0, o_valid=0, done=0, busy=0 and o_data=0 during reset.
REQ-034 SHALL, after reset mid-operation, perform no capture for a read issued before reset.

Configuration
REQ-035 SHALL, with macro PSUM_ACC_RELU_EN defined, compute f(x) per lane as x<0 ? 0 : x.
REQ-036 SHALL, without PSUM_ACC_RELU_EN, compute f(x)=x; no ReLU logic is generated.

Verification
REQ-037 SHALL cover: npass=1, len=16, vectors lane=pos -> 16 outputs equal to the inputs; done pulses once.
REQ-038 SHALL cover: npass=3, every lane 0x0010 each pass -> every output lane 0x0030; exactly 48 o_rd pulses.
REQ-039 SHALL cover: npass=2, lane 0x7000 twice -> 0x7FFF; lane 0x9000 twice -> 0x8000 with RELU off, 0x0000 with RELU on.
REQ-040 SHALL cover: o_ready held 0 for 5 cycles at pos=3 -> o_data stable, no pos advance, then resumes.
REQ-041 SHALL cover: i_valid held 0 mid-tile, and start during ACC -> no o_rd while i_valid=0; start ignored; counts unchanged.
REQ-042 SHALL cover: reset low for 1 cycle right after an o_rd pulse -> IDLE, outputs 0, no capture; a fresh start works normally.

Source files
------------

// File: rtl/psum_acc.sv
// Multi-pass partial-sum accumulator: pops psum vectors from an upstream FIFO, saturating-adds them
// per output position across npass passes, then streams the tile out. Optional ReLU: PSUM_ACC_RELU_EN.
module psum_acc #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int len     = 16,
  parameter int rd_lat  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  input  logic [psum_bw*col-1:0] i_data,
  output logic                   o_rd,
  input  logic                   start,
  input  logic [3:0]             npass,
  output logic [psum_bw*col-1:0] o_data,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int PW = (len > 1) ? $clog2(len) : 1;
  localparam int RW = $clog2(len * 16 + 1);
  localparam logic [PW-1:0] POS_LAST = PW'(len - 1);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t state, state_nx;

  logic [PW-1:0]          pos;
  logic [3:0]             pass;
  logic [3:0]             npass_q;
  logic [RW-1:0]          rd_cnt;
  logic [RW-1:0]          rd_total;
  logic                   inflight;
  logic [rd_lat-1:0]      rd_pipe;
  logic [psum_bw*col-1:0] acc [len];
  logic [psum_bw*col-1:0] acc_cur;
  logic [psum_bw*col-1:0] acc_sum;
  logic                   cap;
  logic                   cap_last;
  logic                   hs;
  logic                   hs_last;

  function automatic logic [psum_bw-1:0] sat_add(input logic [psum_bw-1:0] a,
                                                 input logic [psum_bw-1:0] b);
    logic [psum_bw:0] s;
    s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    if (s[psum_bw] != s[psum_bw-1])
      return s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
    return s[psum_bw-1:0];
  endfunction

  always_comb begin
    acc_cur = acc[pos];
    acc_sum = '0;
    for (int unsigned k = 0; k < col; k++)
      acc_sum[k*psum_bw +: psum_bw] = sat_add(acc_cur[k*psum_bw +: psum_bw],
                                              i_data[k*psum_bw +: psum_bw]);
  end

  // The delay line only yields a capture while accumulating, so a stale tap can never touch the tile.
  always_comb begin
    rd_total = RW'(len) * RW'(npass_q);
    cap      = rd_pipe[rd_lat-1] && (state == ACC);
    cap_last = cap && (pos == POS_LAST) && (pass == npass_q - 4'd1);
    hs       = (state == OUT) && o_ready;
    hs_last  = hs && (pos == POS_LAST);
    state_nx = state;
    o_rd     = 1'b0;
    o_valid  = 1'b0;
    case (state)
      IDLE: if (start) state_nx = ACC;
      ACC: begin
        o_rd = i_valid && !inflight && (rd_cnt < rd_total);
        if (cap_last) state_nx = OUT;
      end
      OUT: begin
        o_valid = 1'b1;
        if (hs_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_data = '0;
    if (state == OUT) begin
      o_data = acc_cur;
`ifdef PSUM_ACC_RELU_EN
      for (int unsigned k = 0; k < col; k++)
        if (acc_cur[k*psum_bw + psum_bw - 1]) o_data[k*psum_bw +: psum_bw] = '0;
`endif
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos      <= '0;
      pass     <= '0;
      npass_q  <= '0;
      rd_cnt   <= '0;
      inflight <= 1'b0;
      rd_pipe  <= '0;
      done     <= 1'b0;
      for (int unsigned i = 0; i < len; i++) acc[i] <= '0;
    end else begin
      rd_pipe <= (rd_pipe << 1) | rd_lat'(o_rd);
      done    <= hs_last;
      if (o_rd) begin
        inflight <= 1'b1;
        rd_cnt   <= rd_cnt + RW'(1);
      end
      if (cap) inflight <= 1'b0;
      case (state)
        IDLE: if (start) begin
          npass_q <= (npass == 4'd0) ? 4'd1 : npass;
          pos     <= '0;
          pass    <= '0;
          rd_cnt  <= '0;
        end
        ACC: if (cap) begin
          acc[pos] <= (pass == 4'd0) ? i_data : acc_sum;
          if (pos == POS_LAST) begin
            pos  <= '0;
            pass <= pass + 4'd1;
          end else begin
            pos <= pos + PW'(1);
          end
        end
        OUT: if (hs) pos <= hs_last ? '0 : pos + PW'(1);
        default: ;
      endcase
    end
  end

endmodule
